// File: rtl/hex_disp_pkg.sv
// Shared types for the hex display counter: digit width, digit type, and
// the count direction encoding used by the up_down switch.
package hex_disp_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] hex_digit_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: divides clk down to a one-cycle tick every PRESCALE enabled
// cycles. The count freezes while enable is low and restarts from zero on
// sync_clr so a clear or load always begins a full count period.
module tick_gen #(
  parameter int PRESCALE = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sync_clr,
  output logic tick
);

  // PRESCALE=1 still needs a 1-bit register; it simply stays at zero.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;

  assign tick = enable && (pre == PRE_LAST);

  // Prescale counter: wraps to zero on the terminal count, holds when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (sync_clr) begin
      pre <= '0;
    end else if (enable) begin
      if (tick) begin
        pre <= '0;
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/hex_digit_counter.sv
// Multi-digit hex up/down counter feeding the 7-segment decoder bank.
// Count and display registers share one next-state value so the display
// tracks the count with no extra latency unless hold freezes it.
module hex_digit_counter
  import hex_disp_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       up_down,
  input  logic                       clear,
  input  logic                       load,
  input  logic [DIGIT_W*NDIGITS-1:0] load_value,
  input  logic                       hold,
  output logic [DIGIT_W*NDIGITS-1:0] digits,
  output logic                       tick,
  output logic                       wrap
);

  localparam int CNT_W = DIGIT_W * NDIGITS;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] display;
  logic             wrap_next;
  logic             sync_clr;
  dir_t             dir;

  assign dir      = dir_t'(up_down);
  assign sync_clr = clear | load;

  // One count step in the selected direction, modulo 2^CNT_W.
  function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] value,
                                                  input dir_t            d);
    if (d == DIR_UP) begin
      return value + CNT_W'(1);
    end
    return value - CNT_W'(1);
  endfunction

  // True when a step from value in direction d rolls over the full range.
  function automatic logic is_wrap(input logic [CNT_W-1:0] value, input dir_t d);
    if (d == DIR_UP) begin
      return &value;
    end
    return ~|value;
  endfunction

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .sync_clr (sync_clr),
    .tick     (tick)
  );

  // Next count: clear beats load beats a tick; a tick coinciding with load is dropped.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_value;
    end else if (tick) begin
      count_next = step_count(count, dir);
      wrap_next  = is_wrap(count, dir);
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

  // Display register: follows the next count unless hold freezes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display <= '0;
    end else if (!hold) begin
      display <= count_next;
    end
  end

  assign digits = display;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed bench for hex_digit_counter with PRESCALE=4, NDIGITS=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hex_digit_counter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        up_down;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic        hold;
  logic [15:0] digits;
  logic        tick;
  logic        wrap;

  int checks;
  int errors;

  hex_digit_counter #(
    .NDIGITS  (4),
    .PRESCALE (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .hold       (hold),
    .digits     (digits),
    .tick       (tick),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Clear count and prescaler with everything else idle.
  task automatic do_clear();
    enable = 1'b0; load = 1'b0; hold = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    enable = 1'b0; load = 1'b1; load_value = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; clear = 1'b0;
    load = 1'b0; load_value = 16'h0000; hold = 1'b0;
    cyc(); cyc();
    checks++;
    if (digits !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: digits=%h tick=%b wrap=%b, required 0000/0/0", digits, tick, wrap);
    end
    reset = 1'b0;
    // Count a little, then pulse reset mid-count between clock edges.
    enable = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    checks++;
    if (digits !== 16'h0001) begin
      errors++;
      $display("FAIL reset_precount: digits=%h, required 0001", digits);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (digits !== 16'h0000 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcount: digits=%h tick=%b, required 0000/0", digits, tick);
    end
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      checks++;
      if (tick !== ((i % 4) == 3) || digits !== 16'(i / 4) || wrap !== 1'b0) begin
        errors++;
        $display("FAIL count_up[%0d]: digits=%h tick=%b wrap=%b, required %h/%b/0",
                 i, digits, tick, wrap, 16'(i / 4), ((i % 4) == 3));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [15:0] exp;
    do_clear();
    do_load(16'hFFFE);
    checks++;
    if (digits !== 16'hFFFE || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_fffe: digits=%h wrap=%b, required FFFE/0", digits, wrap);
    end
    enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      exp = 16'hFFFE + 16'(i / 4);
      checks++;
      if (digits !== exp || wrap !== (i == 8)) begin
        errors++;
        $display("FAIL wrap_up[%0d]: digits=%h wrap=%b, required %h/%b", i, digits, wrap, exp, (i == 8));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap_down();
    logic [15:0] exp;
    do_clear();
    checks++;
    if (digits !== 16'h0000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: digits=%h wrap=%b, required 0000/0", digits, wrap);
    end
    enable = 1'b1; up_down = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp = 16'h0000 - 16'(i / 4);
      checks++;
      if (digits !== exp || wrap !== (i == 4)) begin
        errors++;
        $display("FAIL wrap_down[%0d]: digits=%h wrap=%b, required %h/%b", i, digits, wrap, exp, (i == 4));
      end
    end
    enable = 1'b0; up_down = 1'b1;
    // Loading a wrap value must not pulse wrap.
    do_load(16'h0000);
    checks++;
    if (wrap !== 1'b0 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL load_no_wrap: digits=%h wrap=%b, required 0000/0", digits, wrap);
    end
  endtask

  task automatic test_hold();
    do_clear();
    do_load(16'h0005);
    hold = 1'b1; enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      checks++;
      if (digits !== 16'h0005) begin
        errors++;
        $display("FAIL hold_frozen[%0d]: digits=%h, required 0005", i, digits);
      end
    end
    enable = 1'b0; hold = 1'b0;
    cyc();
    checks++;
    if (digits !== 16'h0008) begin
      errors++;
      $display("FAIL hold_release: digits=%h, required 0008", digits);
    end
    // Clear under hold zeroes only the count; display waits for release.
    hold = 1'b1; clear = 1'b1;
    cyc();
    clear = 1'b0;
    checks++;
    if (digits !== 16'h0008) begin
      errors++;
      $display("FAIL clear_under_hold: digits=%h, required 0008", digits);
    end
    hold = 1'b0;
    cyc();
    checks++;
    if (digits !== 16'h0000) begin
      errors++;
      $display("FAIL clear_hold_release: digits=%h, required 0000", digits);
    end
  endtask

  task automatic test_clear_load_tick();
    do_clear();
    do_load(16'h0042);
    enable = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL pre_tick: tick=%b, required 1", tick);
    end
    clear = 1'b1; load = 1'b1; load_value = 16'h1234;
    cyc();
    clear = 1'b0; load = 1'b0;
    checks++;
    if (digits !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL clear_beats_load: digits=%h tick=%b wrap=%b, required 0000/0/0", digits, tick, wrap);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (tick !== (i == 3) || digits !== 16'(i == 4)) begin
        errors++;
        $display("FAIL tick_after_clear[%0d]: digits=%h tick=%b, required %h/%b",
                 i, digits, tick, 16'(i == 4), (i == 3));
      end
    end
    // Load coinciding with a tick: the tick is discarded.
    for (int i = 0; i < 3; i++) cyc();
    load = 1'b1; load_value = 16'h1234;
    cyc();
    load = 1'b0;
    checks++;
    if (digits !== 16'h1234 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_drops_tick: digits=%h wrap=%b, required 1234/0", digits, wrap);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (tick !== (i == 3) || digits !== (16'h1234 + 16'(i == 4))) begin
        errors++;
        $display("FAIL tick_after_load[%0d]: digits=%h tick=%b, required %h/%b",
                 i, digits, tick, 16'h1234 + 16'(i == 4), (i == 3));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_freeze();
    do_clear();
    enable = 1'b1; up_down = 1'b1;
    cyc(); cyc();
    enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      checks++;
      if (tick !== 1'b0 || digits !== 16'h0000) begin
        errors++;
        $display("FAIL enable_off[%0d]: digits=%h tick=%b, required 0000/0", i, digits, tick);
      end
    end
    enable = 1'b1;
    cyc();
    checks++;
    if (tick !== 1'b1 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL reenable_tick: digits=%h tick=%b, required 0000/1", digits, tick);
    end
    cyc();
    checks++;
    if (tick !== 1'b0 || digits !== 16'h0001) begin
      errors++;
      $display("FAIL reenable_step: digits=%h tick=%b, required 0001/0", digits, tick);
    end
    enable = 1'b0;
  endtask

  task automatic test_async_reset_hold();
    do_load(16'hABCD);
    hold = 1'b1;
    cyc();
    checks++;
    if (digits !== 16'hABCD) begin
      errors++;
      $display("FAIL pre_reset_load: digits=%h, required ABCD", digits);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (digits !== 16'h0000 || wrap !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_midhold: digits=%h wrap=%b tick=%b, required 0000/0/0", digits, wrap, tick);
    end
    @(negedge clk);
    reset = 1'b0; hold = 1'b0;
    cyc();
    checks++;
    if (digits !== 16'h0000) begin
      errors++;
      $display("FAIL post_reset: digits=%h, required 0000", digits);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_hold();
    test_clear_load_tick();
    test_enable_freeze();
    test_async_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_digit_counter.md
Name: hex_digit_counter

Overview:
- Multi-digit hexadecimal up/down counter that produces the 4-bit digit codes consumed by the per-digit hex-to-7-segment decoders.
- An internal prescaler divides the board clock down to a count rate.
- Supports synchronous clear, parallel load, and a display-hold ("lap") function: counting continues while the displayed value stays frozen.
- Sits between the board switches/keys and the display decoder bank.

Parameters:
- NDIGITS, 4, number of hex digits; counter width is 4*NDIGITS bits.
- PRESCALE, 50_000_000, clk cycles per count step; legal range >= 1. PRESCALE=1 means one count step per enabled cycle.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  1 = prescaler runs and count steps on tick; 0 = prescaler and count frozen.
- up_down  input  1  1 = increment, 0 = decrement.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous parallel load of count from load_value.
- load_value  input  4*NDIGITS  value for load; digit i is bits [4i+3:4i].
- hold  input  1  1 = freeze displayed value; counting continues underneath.
- digits  output  4*NDIGITS  displayed value; digit i feeds decoder i.
- tick  output  1  one-cycle pulse on each prescaler terminal count.
- wrap  output  1  one-cycle pulse when count wraps (all-F to 0 up, 0 to all-F down).

Behaviour:
- Reset is asynchronous, active-high. While reset is high: prescaler=0, count=0, display register=0, digits=0, tick=0, wrap=0.
- Prescaler:
  - pre counts 0..PRESCALE-1 while enable=1; holds its value while enable=0.
  - tick=1 combinationally in the cycle where enable=1 and pre==PRESCALE-1; at that edge pre returns to 0.
- Count update at each rising edge, first match wins:
  1. clear=1: count=0, pre=0, wrap=0. Takes priority over load and tick.
  2. load=1: count=load_value, pre=0, wrap=0. A tick in the same cycle is discarded.
  3. tick=1, up_down=1: count=count+1, modulo 2^(4*NDIGITS).
  4. tick=1, up_down=0: count=count-1, modulo 2^(4*NDIGITS).
  5. Otherwise: count holds.
- Wrap:
  - Registered output, high for exactly the one cycle following the edge where count went all-F to 0 (up) or 0 to all-F (down).
  - Never asserted by clear or load, even when the loaded value equals a wrap value.
- Display register:
  - hold=0: loads the same next-state value as count on every edge. digits equals count with zero extra latency.
  - hold=1: keeps its value; count keeps changing.
  - hold falling edge: on the next edge the display loads the current next count value.
  - clear with hold=1 zeroes count only. The display stays frozen until hold is released.
- up_down changes take effect at the next tick; no glitch, no extra step.
- enable=0 with load/clear: load and clear still act.
- Reset mid-count or mid-hold: all state returns to 0 immediately, independent of clk.
- All outputs are registered except tick.

Decomposition:
- Package hex_disp_pkg:
  - localparam DIGIT_W = 4.
  - typedef logic [DIGIT_W-1:0] hex_digit_t.
  - enum dir_t {DIR_DOWN=0, DIR_UP=1}.
- Sub-module tick_gen (parameter PRESCALE): inputs clk, reset, enable, sync_clr; output tick.
- Top level instantiates tick_gen and holds the count, display and wrap registers.
- Downstream, each digit slice drives one decoder instance (instantiated outside this block).

Test Plan (PRESCALE=4, NDIGITS=4):
- Reset pulse mid-count, then enable=1, up_down=1 for 16 clk -> ticks on clk 4,8,12,16; digits 0000→0001→0002→0003→0004; wrap never 1.
- load=1, load_value=16'hFFFE, then count up 2 ticks -> digits FFFE→FFFF→0000; wrap=1 for exactly the cycle after the FFFF→0000 edge.
- Count down from 0000 -> digits FFFF, wrap=1 one cycle; next tick → FFFE, wrap=0.
- At 0x0005, hold=1, run 3 ticks -> digits stays 0005; release hold -> digits 0008 on the next edge.
- clear=1 and load=1 (load_value=1234) in the same cycle as tick -> count=0000, pre=0; the next tick arrives 4 cycles later.
- enable=0 for 10 cycles at pre=2 -> no tick, count unchanged; re-enable -> tick after 2 cycles. Async reset asserted between clk edges -> digits=0000 immediately.
